echo_delay: RTL

Echo/delay effect stage that sits directly downstream of the distortion stage in the guitar-effects sample path, in the 500 kHz sample-clock domain. Each accepted sample is mixed with a delayed copy read from an on-chip circular buffer, optionally fed back into that buffer, and saturated. The result is presented on a valid/ready output toward the output FIFO.

---
 rtl/echo_delay.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/echo_delay.sv
// Echo/delay stage: mixes each accepted sample with a delayed copy from a circular buffer.
// Define ECHO_DELAY_FEEDBACK_EN to feed the scaled echo back into the buffer (regenerating echo).
module echo_delay #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              bypass,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [15:0]       feedback_gain,
    input  logic [15:0]       mix_gain
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = DATA_W + 17;
    localparam int SUM_W  = DATA_W + 18;

    localparam logic [15:0]              GAIN_ONE = 16'h8000;
    localparam logic [DATA_W-1:0]        MAX_VAL  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]        MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]  SAT_MAX  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]  SAT_MIN  = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_OUT
    } state_t;

    function automatic logic [15:0] clamp_gain(input logic [15:0] g);
        return (g > GAIN_ONE) ? GAIN_ONE : g;
    endfunction

    // (d * gain) >>> 15 with the gain zero-extended; arithmetic shift floors toward -inf.
    function automatic logic signed [SUM_W-1:0] scale(input logic [DATA_W-1:0] d,
                                                      input logic [15:0]       g);
        logic signed [PROD_W-1:0] de;
        logic signed [PROD_W-1:0] ge;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] sh;
        de   = {{17{d[DATA_W-1]}}, d};
        ge   = {{(DATA_W+1){1'b0}}, g};
        prod = de * ge;
        sh   = prod >>> 15;
        return {sh[PROD_W-1], sh};
    endfunction

    function automatic logic [DATA_W-1:0] add_sat(input logic [DATA_W-1:0]      x,
                                                  input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] sum;
        sum = $signed({{(SUM_W-DATA_W){x[DATA_W-1]}}, x}) + s;
        if (sum > SAT_MAX) begin
            return MAX_VAL;
        end else if (sum < SAT_MIN) begin
            return MIN_VAL;
        end
        return sum[DATA_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic                bypass_q, bypass_d;
    logic [ADDR_W-1:0]   delay_q, delay_d;
    logic [15:0]         mix_q, mix_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
`ifdef ECHO_DELAY_FEEDBACK_EN
    logic [15:0]         fb_q, fb_d;
    logic [DATA_W-1:0]   fbv;
`else
    logic                unused_feedback_gain;
    assign unused_feedback_gain = ^feedback_gain;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_rd_q;
    logic [ADDR_W-1:0]   ram_rd_addr;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ADDR_W-1:0]   delay_eff;
    logic [DATA_W-1:0]   wet;

    // Handshakes are strict valid/ready: a transfer happens on a rising edge where both are 1;
    // in_ready depends only on state, and out_data is held stable while out_valid waits for out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;

    // A delay of 0 would read the slot about to be written, so it behaves as 1.
    assign delay_eff   = (delay_q == '0) ? ADDR_W'(1) : delay_q;
    assign ram_rd_addr = wr_ptr_q - delay_eff;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        ram_rd_q <= mem[ram_rd_addr];
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        x_d        = x_q;
        bypass_d   = bypass_q;
        delay_d    = delay_q;
        mix_d      = mix_q;
        out_data_d = out_data_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q;
        mem_wdata  = '0;
        wet        = add_sat(x_q, scale(ram_rd_q, mix_q));
`ifdef ECHO_DELAY_FEEDBACK_EN
        fb_d       = fb_q;
        fbv        = add_sat(x_q, scale(ram_rd_q, fb_q));
`endif

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (&clr_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    x_d      = in_data;
                    bypass_d = bypass;
                    delay_d  = delay_len;
                    mix_d    = clamp_gain(mix_gain);
`ifdef ECHO_DELAY_FEEDBACK_EN
                    fb_d     = clamp_gain(feedback_gain);
`endif
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                out_data_d = bypass_q ? x_q : wet;
                mem_we     = 1'b1;
                mem_waddr  = wr_ptr_q;
`ifdef ECHO_DELAY_FEEDBACK_EN
                mem_wdata  = bypass_q ? x_q : fbv;
`else
                mem_wdata  = x_q;
`endif
                wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Reset discards the in-flight sample, including its buffer write.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            x_q        <= '0;
            bypass_q   <= 1'b0;
            delay_q    <= '0;
            mix_q      <= '0;
            out_data_q <= '0;
`ifdef ECHO_DELAY_FEEDBACK_EN
            fb_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            x_q        <= x_d;
            bypass_q   <= bypass_d;
            delay_q    <= delay_d;
            mix_q      <= mix_d;
            out_data_q <= out_data_d;
`ifdef ECHO_DELAY_FEEDBACK_EN
            fb_q       <= fb_d;
`endif
        end
    end

endmodule
